// File: rtl/u712_pkg.sv
// rtl/u712_pkg.sv - shared types and limits for the U712 bus-termination logic
package u712_pkg;

    localparam int U712_MAX_TERM_SRC = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ASSERT = 2'd2,
        NEGATE = 2'd3
    } term_state_t;

endpackage

// File: rtl/u712_prio_enc.sv
// rtl/u712_prio_enc.sv - lowest-index priority encoder with multi-hot detect
module u712_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [2:0]   idx,
    output logic         valid,
    output logic         multi
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 3'(i);
            end
        end
    end

    assign valid = |req;
    // Clearing the lowest set bit leaves something only when two or more were set
    assign multi = (req & (req - N'(1))) != '0;

endmodule

// File: rtl/u712_term_arb.sv
// rtl/u712_term_arb.sv - 68040 termination arbiter; watchdog built when U712_TERM_WATCHDOG_EN is defined
module u712_term_arb
    import u712_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int TIMEOUT_CYC = 1023,
    parameter int TO_W        = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic               CLK80,
    input  logic               RESETn,
    input  logic               BCLK_EN,
    input  logic               TSn,
    input  logic [NUM_SRC-1:0] SRC_ACK,
    input  logic [NUM_SRC-1:0] SRC_TBI,
    input  logic [NUM_SRC-1:0] SRC_TCI,
    input  logic [NUM_SRC-1:0] SRC_ERR,
    output logic               TACKn,
    output logic               TBIn,
    output logic               TCIn,
    output logic               TEAn,
    output logic               TERM_OEn,
    output logic               CYCLE_ACTIVE,
    output logic [2:0]         WINNER,
    output logic               COLLISION,
    output logic               TIMEOUT
);

    term_state_t        state_q, state_d;
    logic [NUM_SRC-1:0] pend_ack_q, pend_ack_d;
    logic [NUM_SRC-1:0] pend_err_q, pend_err_d;
    logic [NUM_SRC-1:0] pend_tbi_q, pend_tbi_d;
    logic [NUM_SRC-1:0] pend_tci_q, pend_tci_d;
    logic               tack_n_q, tack_n_d;
    logic               tbi_n_q, tbi_n_d;
    logic               tci_n_q, tci_n_d;
    logic               tea_n_q, tea_n_d;
    logic               term_oe_n_q, term_oe_n_d;
    logic [2:0]         winner_q, winner_d;
    logic               collision_q, collision_d;

    logic [NUM_SRC-1:0] eff_ack, eff_err, eff_tbi, eff_tci;
    logic [U712_MAX_TERM_SRC-1:0] err_w, tbi_w, tci_w;
    logic [2:0]         win_idx;
    logic               win_valid, win_multi;

    // Requests seen this cycle count as if already pending; attributes
    // follow the ACK that carried them so a short pulse keeps its TBI/TCI
    assign eff_ack = pend_ack_q | SRC_ACK;
    assign eff_err = pend_err_q | SRC_ERR;
    assign eff_tbi = (SRC_ACK & SRC_TBI) | (~SRC_ACK & pend_tbi_q);
    assign eff_tci = (SRC_ACK & SRC_TCI) | (~SRC_ACK & pend_tci_q);

    // Widen to the maximum source count so the 3-bit winner indexes cleanly
    assign err_w = U712_MAX_TERM_SRC'(eff_err);
    assign tbi_w = U712_MAX_TERM_SRC'(eff_tbi);
    assign tci_w = U712_MAX_TERM_SRC'(eff_tci);

    u712_prio_enc #(
        .N(NUM_SRC)
    ) u_prio (
        .req  (eff_ack | eff_err),
        .idx  (win_idx),
        .valid(win_valid),
        .multi(win_multi)
    );

`ifdef U712_TERM_WATCHDOG_EN
    localparam logic [TO_W-1:0] WD_LIMIT = TO_W'(TIMEOUT_CYC);
    logic [TO_W-1:0] wd_q, wd_d, wd_inc;
    logic            timeout_q, timeout_d;

    assign wd_inc  = (wd_q == WD_LIMIT) ? wd_q : wd_q + TO_W'(1);
    assign TIMEOUT = timeout_q;
`else
    assign TIMEOUT = 1'b0;
`endif

    // Next-state and next-strobe decode; every transition waits for a BCLK edge
    always_comb begin
        state_d     = state_q;
        pend_ack_d  = pend_ack_q;
        pend_err_d  = pend_err_q;
        pend_tbi_d  = pend_tbi_q;
        pend_tci_d  = pend_tci_q;
        tack_n_d    = tack_n_q;
        tbi_n_d     = tbi_n_q;
        tci_n_d     = tci_n_q;
        tea_n_d     = tea_n_q;
        term_oe_n_d = term_oe_n_q;
        winner_d    = winner_q;
        collision_d = 1'b0;
`ifdef U712_TERM_WATCHDOG_EN
        wd_d        = wd_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (BCLK_EN && !TSn) begin
                    state_d    = WAIT;
                    pend_ack_d = '0;
                    pend_err_d = '0;
                    pend_tbi_d = '0;
                    pend_tci_d = '0;
`ifdef U712_TERM_WATCHDOG_EN
                    wd_d       = '0;
`endif
                end
            end
            WAIT: begin
                pend_ack_d = eff_ack;
                pend_err_d = eff_err;
                pend_tbi_d = eff_tbi;
                pend_tci_d = eff_tci;
                if (BCLK_EN) begin
                    if (win_valid) begin
                        state_d     = ASSERT;
                        term_oe_n_d = 1'b0;
                        winner_d    = win_idx;
                        collision_d = win_multi;
                        if (err_w[win_idx]) begin
                            tea_n_d = 1'b0;
                        end else begin
                            tack_n_d = 1'b0;
                            tbi_n_d  = !tbi_w[win_idx];
                            tci_n_d  = !tci_w[win_idx];
                        end
                    end
`ifdef U712_TERM_WATCHDOG_EN
                    else begin
                        wd_d = wd_inc;
                        if (wd_inc == WD_LIMIT) begin
                            state_d     = ASSERT;
                            term_oe_n_d = 1'b0;
                            tea_n_d     = 1'b0;
                            timeout_d   = 1'b1;
                        end
                    end
`endif
                end
            end
            ASSERT: begin
                if (BCLK_EN) begin
                    state_d  = NEGATE;
                    tack_n_d = 1'b1;
                    tbi_n_d  = 1'b1;
                    tci_n_d  = 1'b1;
                    tea_n_d  = 1'b1;
                end
            end
            NEGATE: begin
                if (BCLK_EN) begin
                    state_d     = IDLE;
                    term_oe_n_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered strobes; reset releases the pads immediately
    always_ff @(posedge CLK80 or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= IDLE;
            pend_ack_q  <= '0;
            pend_err_q  <= '0;
            pend_tbi_q  <= '0;
            pend_tci_q  <= '0;
            tack_n_q    <= 1'b1;
            tbi_n_q     <= 1'b1;
            tci_n_q     <= 1'b1;
            tea_n_q     <= 1'b1;
            term_oe_n_q <= 1'b1;
            winner_q    <= '0;
            collision_q <= 1'b0;
`ifdef U712_TERM_WATCHDOG_EN
            wd_q        <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pend_ack_q  <= pend_ack_d;
            pend_err_q  <= pend_err_d;
            pend_tbi_q  <= pend_tbi_d;
            pend_tci_q  <= pend_tci_d;
            tack_n_q    <= tack_n_d;
            tbi_n_q     <= tbi_n_d;
            tci_n_q     <= tci_n_d;
            tea_n_q     <= tea_n_d;
            term_oe_n_q <= term_oe_n_d;
            winner_q    <= winner_d;
            collision_q <= collision_d;
`ifdef U712_TERM_WATCHDOG_EN
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign TACKn        = tack_n_q;
    assign TBIn         = tbi_n_q;
    assign TCIn         = tci_n_q;
    assign TEAn         = tea_n_q;
    assign TERM_OEn     = term_oe_n_q;
    assign WINNER       = winner_q;
    assign COLLISION    = collision_q;
    assign CYCLE_ACTIVE = (state_q == WAIT) || (state_q == ASSERT);

endmodule

// File: tb/tb_u712_term_arb.sv
// tb/tb_u712_term_arb.sv - bench for u712_term_arb with a transaction-level model
module tb_u712_term_arb;

`ifdef U712_TERM_WATCHDOG_EN
    localparam int TB_TO = 4;
`else
    localparam int TB_TO = 1023;
`endif

    logic       CLK80   = 1'b0;
    logic       RESETn  = 1'b0;
    logic       BCLK_EN = 1'b0;
    logic       TSn     = 1'b1;
    logic [3:0] SRC_ACK = '0;
    logic [3:0] SRC_TBI = '0;
    logic [3:0] SRC_TCI = '0;
    logic [3:0] SRC_ERR = '0;
    logic       TACKn, TBIn, TCIn, TEAn, TERM_OEn, CYCLE_ACTIVE, COLLISION, TIMEOUT;
    logic [2:0] WINNER;

    int errors = 0;
    int checks = 0;

    u712_term_arb #(
        .NUM_SRC    (4),
        .TIMEOUT_CYC(TB_TO)
    ) dut (
        .CLK80       (CLK80),
        .RESETn      (RESETn),
        .BCLK_EN     (BCLK_EN),
        .TSn         (TSn),
        .SRC_ACK     (SRC_ACK),
        .SRC_TBI     (SRC_TBI),
        .SRC_TCI     (SRC_TCI),
        .SRC_ERR     (SRC_ERR),
        .TACKn       (TACKn),
        .TBIn        (TBIn),
        .TCIn        (TCIn),
        .TEAn        (TEAn),
        .TERM_OEn    (TERM_OEn),
        .CYCLE_ACTIVE(CYCLE_ACTIVE),
        .WINNER      (WINNER),
        .COLLISION   (COLLISION),
        .TIMEOUT     (TIMEOUT)
    );

    always #5 CLK80 = ~CLK80;

    // BCLK is CLK80/2: enable is high on every other CLK80 edge
    initial begin
        forever begin
            @(posedge CLK80);
            #1 BCLK_EN = !BCLK_EN;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Bus cycle viewed as: open -> (collecting requests) -> terminated ->
    // one BCLK of strobe assertion -> one BCLK of negation -> closed.
    bit         m_busy = 0;
    bit         m_collecting = 0;
    int         m_bclks_after = 0;
    int         m_bclks_waited = 0;
    bit [3:0]   m_ack = 0, m_err = 0, m_tbi = 0, m_tci = 0;
    int         m_win;
    logic       e_tack = 1, e_tbi = 1, e_tci = 1, e_tea = 1, e_oe = 1, e_coll = 0, e_to = 0;
    logic [2:0] e_win = 0;

    task automatic model_reset();
        m_busy = 0; m_collecting = 0; m_bclks_after = 0; m_bclks_waited = 0;
        m_ack = 0; m_err = 0; m_tbi = 0; m_tci = 0;
        e_tack = 1; e_tbi = 1; e_tci = 1; e_tea = 1; e_oe = 1;
        e_coll = 0; e_to = 0; e_win = 0;
    endtask

    task automatic model_step();
        e_coll = 0;
        e_to   = 0;
        if (!m_busy) begin
            if (BCLK_EN && !TSn) begin
                m_busy = 1; m_collecting = 1; m_bclks_waited = 0;
                m_ack = 0; m_err = 0; m_tbi = 0; m_tci = 0;
            end
        end else if (m_collecting) begin
            for (int i = 0; i < 4; i++) begin
                if (SRC_ACK[i]) begin
                    m_ack[i] = 1; m_tbi[i] = SRC_TBI[i]; m_tci[i] = SRC_TCI[i];
                end
                if (SRC_ERR[i]) m_err[i] = 1;
            end
            if (BCLK_EN) begin
                if ((m_ack | m_err) != 0) begin
                    m_win = -1;
                    for (int i = 3; i >= 0; i--) if (m_ack[i] || m_err[i]) m_win = i;
                    e_win  = 3'(m_win);
                    e_coll = ($countones(m_ack | m_err) > 1);
                    if (m_err[m_win]) e_tea = 0;
                    else begin
                        e_tack = 0; e_tbi = !m_tbi[m_win]; e_tci = !m_tci[m_win];
                    end
                    e_oe = 0; m_collecting = 0; m_bclks_after = 0;
                end else begin
                    m_bclks_waited++;
`ifdef U712_TERM_WATCHDOG_EN
                    if (m_bclks_waited == TB_TO) begin
                        e_tea = 0; e_oe = 0; e_to = 1;
                        m_collecting = 0; m_bclks_after = 0;
                    end
`endif
                end
            end
        end else if (BCLK_EN) begin
            m_bclks_after++;
            if (m_bclks_after == 1) begin
                e_tack = 1; e_tbi = 1; e_tci = 1; e_tea = 1;
            end else begin
                e_oe = 1; m_busy = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK80 or negedge RESETn);
            if (!RESETn) model_reset();
            else model_step();
        end
    end

    // Every cycle: DUT outputs against the model, sampled mid-cycle
    initial begin
        forever begin
            @(negedge CLK80);
            chk("cmp_TACKn", TACKn, e_tack);
            chk("cmp_TBIn", TBIn, e_tbi);
            chk("cmp_TCIn", TCIn, e_tci);
            chk("cmp_TEAn", TEAn, e_tea);
            chk("cmp_TERM_OEn", TERM_OEn, e_oe);
            chk("cmp_CYCLE_ACTIVE", CYCLE_ACTIVE, m_busy && (m_collecting || m_bclks_after == 0));
            chk("cmp_WINNER", WINNER, e_win);
            chk("cmp_COLLISION", COLLISION, e_coll);
            chk("cmp_TIMEOUT", TIMEOUT, e_to);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic sync_bclk();
        int n = 0;
        do begin
            @(posedge CLK80);
            n++;
        end while (!BCLK_EN && n < 8);
        if (!BCLK_EN) begin
            checks++;
            errors++;
            $display("FAIL sync_bclk no BCLK_EN edge within 8 cycles");
        end
    endtask

    task automatic start_cycle();
        sync_bclk();
        #1 TSn = 1'b0;
        sync_bclk();
        #1 TSn = 1'b1;
    endtask

    task automatic finish_cycle();
        sync_bclk();
        sync_bclk();
        #1;
    endtask

    initial begin
        int n;
        int tack_lows;
        repeat (4) @(posedge CLK80);
        #1 RESETn = 1'b1;
        chk("rst_TACKn", TACKn, 1);
        chk("rst_TEAn", TEAn, 1);
        chk("rst_TERM_OEn", TERM_OEn, 1);
        chk("rst_CYCLE_ACTIVE", CYCLE_ACTIVE, 0);
        chk("rst_WINNER", WINNER, 0);

        // Source 1 pulse with TBI=1, TCI=0, attributes dropped with the pulse
        start_cycle();
        SRC_ACK = 4'b0010; SRC_TBI = 4'b0010; SRC_TCI = 4'b0000;
        @(posedge CLK80);
        #1 SRC_ACK = '0; SRC_TBI = '0;
        sync_bclk();
        #1;
        chk("t1_TACKn", TACKn, 0);
        chk("t1_TBIn", TBIn, 0);
        chk("t1_TCIn", TCIn, 1);
        chk("t1_WINNER", WINNER, 1);
        chk("t1_TERM_OEn", TERM_OEn, 0);
        @(posedge CLK80);
        #1 chk("t1_TACKn_2nd", TACKn, 0);
        @(posedge CLK80);
        #1;
        chk("t1_negate_TACKn", TACKn, 1);
        chk("t1_negate_OEn", TERM_OEn, 0);
        sync_bclk();
        #1 chk("t1_idle_OEn", TERM_OEn, 1);

        // Sources 2 and 0 pending together: 0 wins, 2 is discarded
        start_cycle();
        SRC_ACK = 4'b0100;
        @(posedge CLK80);
        #1 SRC_ACK = 4'b0001;
        sync_bclk();
        #1 SRC_ACK = '0;
        chk("t2_COLLISION", COLLISION, 1);
        chk("t2_WINNER", WINNER, 0);
        chk("t2_TACKn", TACKn, 0);
        @(posedge CLK80);
        #1 chk("t2_COLLISION_pulse", COLLISION, 0);
        finish_cycle();
        tack_lows = 0;
        repeat (6) begin
            @(posedge CLK80);
            #1 if (TACKn == 1'b0) tack_lows++;
        end
        chk("t2_no_second_tack", tack_lows, 0);

        // Bus error from source 3 pulsed one CLK80 ahead of the BCLK edge
        start_cycle();
        SRC_ERR = 4'b1000;
        @(posedge CLK80);
        #1 SRC_ERR = '0;
        sync_bclk();
        #1;
        chk("t3_TEAn", TEAn, 0);
        chk("t3_TACKn", TACKn, 1);
        chk("t3_WINNER", WINNER, 3);
        finish_cycle();

`ifdef U712_TERM_WATCHDOG_EN
        // Watchdog fires on the 4th BCLK in WAIT
        start_cycle();
        n = 0;
        while (TEAn && n < 10) begin
            sync_bclk();
            #1 n++;
        end
        chk("t4_wd_bclks", n, 4);
        chk("t4_TIMEOUT", TIMEOUT, 1);
        chk("t4_WINNER_kept", WINNER, 3);
        chk("t4_TACKn", TACKn, 1);
        @(posedge CLK80);
        #1 chk("t4_TIMEOUT_pulse", TIMEOUT, 0);
        finish_cycle();
        // A request on the timeout edge beats the watchdog
        start_cycle();
        repeat (3) sync_bclk();
        #1 SRC_ACK = 4'b0010;
        sync_bclk();
        #1 SRC_ACK = '0;
        chk("t4b_TACKn", TACKn, 0);
        chk("t4b_TEAn", TEAn, 1);
        chk("t4b_TIMEOUT", TIMEOUT, 0);
        chk("t4b_WINNER", WINNER, 1);
        finish_cycle();
`else
        // No watchdog: WAIT persists
        start_cycle();
        repeat (100) sync_bclk();
        #1;
        chk("t4_still_active", CYCLE_ACTIVE, 1);
        chk("t4_TEAn", TEAn, 1);
        chk("t4_TIMEOUT", TIMEOUT, 0);
        SRC_ACK = 4'b0001;
        sync_bclk();
        #1 SRC_ACK = '0;
        chk("t4_late_TACKn", TACKn, 0);
        chk("t4_late_WINNER", WINNER, 0);
        finish_cycle();
`endif

        // Reset while TACKn is low releases everything without a clock
        start_cycle();
        SRC_ACK = 4'b0010;
        sync_bclk();
        #1 SRC_ACK = '0;
        chk("t5_TACKn_low", TACKn, 0);
        #1 RESETn = 1'b0;
        #1;
        chk("t5_TACKn", TACKn, 1);
        chk("t5_TEAn", TEAn, 1);
        chk("t5_TBIn", TBIn, 1);
        chk("t5_TCIn", TCIn, 1);
        chk("t5_TERM_OEn", TERM_OEn, 1);
        chk("t5_CYCLE_ACTIVE", CYCLE_ACTIVE, 0);
        chk("t5_WINNER", WINNER, 0);
        repeat (3) @(posedge CLK80);
        #1 RESETn = 1'b1;
        start_cycle();
        SRC_ACK = 4'b0100;
        sync_bclk();
        #1 SRC_ACK = '0;
        chk("t5_after_TACKn", TACKn, 0);
        chk("t5_after_WINNER", WINNER, 2);
        finish_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/u712_term_arb.md
# u712_term_arb

Parametrised 68040 bus-cycle termination arbiter for the U712 FPGA. It is the generalised successor to the fixed two-source register/chip-RAM terminator. It collects termination requests from `NUM_SRC` cycle engines (register, chip RAM, ATA, PCI bridge, …), picks one per bus cycle by fixed priority, and drives registered TACKn/TBIn/TCIn/TEAn aligned to BCLK (CLK40) edges. It also adds a bus-error path and a watchdog timeout that the previous generation lacked.

## Interface
Parameters:
- `NUM_SRC`, 4: number of termination sources; legal range 1–8.
- `TIMEOUT_CYC`, 1023: BCLK cycles before watchdog bus error; must be ≥2.
- `TO_W`, `$clog2(TIMEOUT_CYC+1)`: watchdog counter width (derived; do not override).

Ports:
- `CLK80` in 1: sole clock; all state changes on rising edge.
- `RESETn` in 1: reset, asynchronous, active-low.
- `BCLK_EN` in 1: high for the one CLK80 cycle whose rising edge coincides with a BCLK rising edge.
- `TSn` in 1: 040 transfer start; sampled only when `BCLK_EN`=1.
- `SRC_ACK` in `NUM_SRC`: per-source terminate request; pulse (≥1 CLK80) or level.
- `SRC_TBI` in `NUM_SRC`: per-source burst-inhibit attribute; valid with `SRC_ACK`.
- `SRC_TCI` in `NUM_SRC`: per-source cache-inhibit attribute; valid with `SRC_ACK`.
- `SRC_ERR` in `NUM_SRC`: per-source bus-error request.
- `TACKn`, `TBIn`, `TCIn`, `TEAn` out 1 each: registered termination strobes, active-low.
- `TERM_OEn` out 1: output enable for the strobe pads, active-low.
- `CYCLE_ACTIVE` out 1: a bus cycle is open (WAIT or ASSERT).
- `WINNER` out 3: index of the source that terminated the last cycle.
- `COLLISION` out 1: one-CLK80 pulse when more than one source was pending at termination.
- `TIMEOUT` out 1: one-CLK80 pulse when the watchdog fires.

## Operation
- States are IDLE, WAIT, ASSERT, NEGATE. In every state, transitions occur only on edges with `BCLK_EN`=1.
- **IDLE:**
  - Strobes are high and `TERM_OEn`=1.
  - `TSn`=0 → WAIT. On entry, clear the watchdog and pending register.
- **WAIT:**
  - Every CLK80, `pend_ack |= SRC_ACK` and `pend_err |= SRC_ERR`.
  - Define `eff_ack = pend_ack | SRC_ACK` and `eff_err = pend_err | SRC_ERR`.
  - At `BCLK_EN`, if any `eff_err` or `eff_ack` bit is set, select the lowest index set in `eff_err | eff_ack`.
  - If the winner's error bit is set: TEAn=0, TACKn=1.
  - Otherwise: TACKn=0, TBIn=`!SRC_TBI[w]`, TCIn=`!SRC_TCI[w]`.
  - Set `TERM_OEn`=0, latch `WINNER`, pulse `COLLISION` if popcount(`eff_ack|eff_err`)>1, then go to ASSERT. Losing requests are discarded.
- **ASSERT:** held for exactly one BCLK. The next `BCLK_EN` → NEGATE with all strobes high.
- **NEGATE:** strobes are driven high for one BCLK. The next `BCLK_EN` → IDLE with `TERM_OEn`=1.
- `TSn` is ignored outside IDLE. A `TSn` seen in NEGATE is lost; the 040 cannot issue one there.
- Attributes are captured in the same edge as the request, so sources must hold TBI/TCI valid while their ACK is high.

## Timing
- Reset values:
  - TACKn=TBIn=TCIn=TEAn=1 and `TERM_OEn`=1.
  - `CYCLE_ACTIVE`=0, `WINNER`=0, `COLLISION`=0, `TIMEOUT`=0.
  - State is IDLE, pending registers and watchdog are 0.
- Reset asserted mid-cycle releases all outputs immediately (asynchronously).
- Latency:
  - An ACK present in the `BCLK_EN` cycle produces TACKn low from that edge, so the minimum is 0 extra BCLK.
  - An ACK arriving just after `BCLK_EN` waits one BCLK (2 CLK80 cycles).
- TACKn is low for exactly one BCLK (2 CLK80 cycles) per cycle, and is never asserted together with TEAn.
- Watchdog:
  - Increments on each `BCLK_EN` in WAIT and saturates at `TIMEOUT_CYC`.
  - On reaching `TIMEOUT_CYC` with nothing pending: TEAn=0, `TIMEOUT` pulses, → ASSERT, and `WINNER` is unchanged.
  - A request present on the same edge wins over the timeout.

## Configuration
- `U712_TERM_WATCHDOG_EN`:
  - Defined: the watchdog counter and timeout path are built as above.
  - Undefined: no counter logic exists, WAIT persists indefinitely, and `TIMEOUT` is tied to 0.

## Structure
- Shared package `u712_pkg` holds the state enum `term_state_t` (IDLE/WAIT/ASSERT/NEGATE) and constant `U712_MAX_TERM_SRC`=8.
- Sub-module `u712_prio_enc` is a parametrised lowest-index priority encoder with a multi-hot detect output. It is instanced once on `eff_ack|eff_err`.

## Test plan
- Reset, then TSn low at a BCLK edge, then SRC_ACK[1] pulsed with TBI=1 and TCI=0: TACKn=0, TBIn=0, TCIn=1 for 2 CLK80 cycles, `WINNER`=1, then NEGATE, then `TERM_OEn`=1.
- SRC_ACK[2] and SRC_ACK[0] pending together: source 0 wins, `COLLISION` pulses, and the source 2 request is dropped (no second TACKn).
- SRC_ERR[3] pulsed one CLK80 before `BCLK_EN`: TEAn=0, TACKn stays 1, `WINNER`=3.
- With the macro defined and TIMEOUT_CYC=4, no requests: TEAn low after 4 BCLK in WAIT and `TIMEOUT` pulses. With the macro undefined, the bench stays in WAIT for 100 BCLK.
- RESETn dropped while TACKn=0: all strobes and `TERM_OEn` go to 1 without waiting for a clock. After release, a new TSn is accepted normally.
